// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache -- direct-mapped, one-word-per-line instruction cache.
//
// Sits between the instruction fetcher and the memory controller. A hit is
// answered one cycle after the request is sampled; a miss issues a single
// word read, installs the returned word and answers the fetcher in the same
// edge. A misbranch from the ROB aborts any in-flight fill and releases the
// memory port immediately. Every answer is followed by one DONE cycle in
// which the fetcher request is ignored while it deasserts.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global ready; when low all state and outputs hold
//   in_fetcher_ce     fetch request (held with stable address until answered)
//   in_fetcher_addr   fetch PC, word aligned; bits [17:2] select the line
//   out_fetcher_ce    one-cycle pulse: out_fetcher_instr is valid
//   out_fetcher_instr instruction word for the answered request
//   out_mem_ce        word-read request, held until in_mem_ce
//   out_mem_addr      word address of the fill
//   in_mem_ce         one-cycle pulse: in_mem_data holds the requested word
//   in_mem_data       fill data
//   in_rob_misbranch  flush pulse; highest priority in every state
// -----------------------------------------------------------------------------
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        in_fetcher_ce,
  input  logic [31:0] in_fetcher_addr,
  output logic        out_fetcher_ce,
  output logic [31:0] out_fetcher_instr,
  output logic        out_mem_ce,
  output logic [31:0] out_mem_addr,
  input  logic        in_mem_ce,
  input  logic [31:0] in_mem_data,
  input  logic        in_rob_misbranch
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e      state_q, state_d;
  logic        fetch_ce_q, fetch_ce_d;
  logic [31:0] instr_q, instr_d;
  logic        mem_ce_q, mem_ce_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        fill_we;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Request decode (from the live fetch address).
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit;

  // Fill decode: the latched miss address is out_mem_addr itself.
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;

  // Byte-offset bits of the PC carry no information for a word fetch.
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_fetcher_addr[1:0];

  assign req_idx  = in_fetcher_addr[INDEX_BITS+1:2];
  assign req_tag  = in_fetcher_addr[17:INDEX_BITS+2];
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[17:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_ce_d = 1'b0;
    instr_d    = instr_q;
    mem_ce_d   = mem_ce_q;
    mem_addr_d = mem_addr_q;
    fill_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_fetcher_ce) begin
          if (hit) begin
            fetch_ce_d = 1'b1;
            instr_d    = data_q[req_idx];
            state_d    = DONE;
          end else begin
            mem_ce_d   = 1'b1;
            mem_addr_d = {in_fetcher_addr[31:2], 2'b00};
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        if (in_mem_ce) begin
          fill_we    = 1'b1;
          mem_ce_d   = 1'b0;
          fetch_ce_d = 1'b1;
          instr_d    = in_mem_data;
          state_d    = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Misbranch overrides everything: drop the fill, answer nothing,
    // and leave the arrays (including valid bits) untouched.
    if (in_rob_misbranch) begin
      state_d    = IDLE;
      fetch_ce_d = 1'b0;
      instr_d    = instr_q;
      mem_ce_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      fill_we    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_ce_q <= 1'b0;
      instr_q    <= '0;
      mem_ce_q   <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      fetch_ce_q <= fetch_ce_d;
      instr_q    <= instr_d;
      mem_ce_q   <= mem_ce_d;
      mem_addr_q <= mem_addr_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data storage are deliberately not reset; the valid bits
  // guard every read, and leaving them reset-free lets them map to RAM.
  always_ff @(posedge clk) begin
    if (rdy && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= in_mem_data;
    end
  end

  assign out_fetcher_ce    = fetch_ce_q;
  assign out_fetcher_instr = instr_q;
  assign out_mem_ce        = mem_ce_q;
  assign out_mem_addr      = mem_addr_q;

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the fetcher and the memory controller. It serves fetch requests in one cycle on a hit. On a miss it sequences a single 32-bit word read through the memory controller, installs the word, then answers the fetcher. It aborts any in-flight fill when the ROB signals a misbranch, so the memory port is released at once.

## Interface
- INDEX_BITS, 6, log2 of line count (64 lines); tag width = 16 - INDEX_BITS
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- rdy  input  1  global ready; when low, all state and outputs hold
- in_fetcher_ce  input  1  fetch request, held high with stable address until answered
- in_fetcher_addr  input  32  fetch PC, word aligned; bits [17:2] used
- out_fetcher_ce  output  1  one-cycle pulse: out_fetcher_instr valid
- out_fetcher_instr  output  32  instruction word for the answered request
- out_mem_ce  output  1  word-read request to the memory controller, held until in_mem_ce
- out_mem_addr  output  32  word address of the fill
- in_mem_ce  input  1  one-cycle pulse: in_mem_data holds the requested word
- in_mem_data  input  32  fill data
- in_rob_misbranch  input  1  flush pulse from ROB

## Operation
- Storage per line: valid bit, tag, 32-bit data.
- Index = addr[INDEX_BITS+1:2]; tag = addr[17:INDEX_BITS+2].
- Hit = valid[index] && tag[index] == addr tag.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - in_fetcher_ce && hit -> out_fetcher_ce=1, out_fetcher_instr=data[index]; go to DONE.
  - in_fetcher_ce && miss -> out_mem_ce=1, out_mem_addr={in_fetcher_addr[31:2],2'b00}; latch address; go to FILL.
- FILL: hold out_mem_ce and out_mem_addr. On in_mem_ce:
  - Write data, tag and valid=1 to the latched index.
  - out_mem_ce=0, out_fetcher_ce=1, out_fetcher_instr=in_mem_data.
  - Go to DONE.
- DONE: out_fetcher_ce=0, in_fetcher_ce ignored (fetcher is still deasserting); go to IDLE.
- in_rob_misbranch (any state, highest priority):
  - Next state IDLE; out_mem_ce=0, out_fetcher_ce=0.
  - A same-cycle in_mem_ce is discarded; the line is not written.
  - A same-cycle IDLE request is not served.
- Valid bits are never cleared except by rst; a misbranch does not invalidate lines.
- Conflicting addresses with the same index evict by overwrite on fill; no replacement state.
- rdy low: FSM, arrays and all registered outputs frozen. An in_mem_ce arriving while rdy is low is not recorded.

## Timing
- All outputs are registered.
- Reset values: out_fetcher_ce=0, out_fetcher_instr=0, out_mem_ce=0, out_mem_addr=0, state=IDLE, all valid=0.
- Hit latency: request sampled at edge N -> out_fetcher_ce high during cycle N+1.
- Hit throughput: one instruction per 2 cycles (IDLE, DONE).
- Miss latency: out_mem_ce high from cycle N+1. If in_mem_ce is sampled at edge M, out_fetcher_ce is high during cycle M+1.
- A fill never overlaps another fill; at most one outstanding memory request.
- rst asserted mid-fill: outputs clear immediately (asynchronously). After release the cache is empty and the next request misses.
- Same-address request right after its fill completes: hit, no memory access.

## Test plan
- Cold miss: rst, then request 0x0000_0000 -> out_mem_ce=1 with addr 0x0; respond in_mem_ce with 0x0010_0093 -> next cycle out_fetcher_ce pulse, instr 0x0010_0093, out_mem_ce=0.
- Hit: repeat 0x0 after DONE -> out_fetcher_ce one cycle after request, instr 0x0010_0093, out_mem_ce stays 0.
- Conflict: fill 0x0000_0100 (same index as 0x0, INDEX_BITS=6) with 0xDEAD_BEEF; then request 0x0 -> miss, new fill issued.
- Misbranch during FILL, coincident with in_mem_ce (0x1234_5678) -> out_mem_ce=0, no out_fetcher_ce, state IDLE; a later request for the same address still misses.
- rdy low for 3 cycles during FILL -> out_mem_ce and out_mem_addr unchanged; fill completes normally after rdy returns.
- Async rst mid-FILL -> out_mem_ce drops without a clock edge; the previously filled address misses afterwards.
